// File: rtl/l1_arbiter_if.sv
// Bus bundle between the L1 I/D cache controllers, the arbiter and the L2 port.
// The arbiter connects through the slave modport; the environment drives through master.
interface l1_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 256
);
   logic                  i_arb_read;
   logic                  i_arb_write;
   logic [ADDR_WIDTH-1:0] i_arb_addr;
   logic [LINE_WIDTH-1:0] i_arb_wdata;
   logic                  i_arb_resp;
   logic                  d_arb_read;
   logic                  d_arb_write;
   logic [ADDR_WIDTH-1:0] d_arb_addr;
   logic [LINE_WIDTH-1:0] d_arb_wdata;
   logic                  d_arb_resp;
   logic [LINE_WIDTH-1:0] arb_rdata;
   logic                  l2_read;
   logic                  l2_write;
   logic [ADDR_WIDTH-1:0] l2_addr;
   logic [LINE_WIDTH-1:0] l2_wdata;
   logic [LINE_WIDTH-1:0] l2_rdata;
   logic                  l2_resp;

   modport slave (
      input  i_arb_read, i_arb_write, i_arb_addr, i_arb_wdata,
      input  d_arb_read, d_arb_write, d_arb_addr, d_arb_wdata,
      input  l2_rdata, l2_resp,
      output i_arb_resp, d_arb_resp, arb_rdata,
      output l2_read, l2_write, l2_addr, l2_wdata
   );

   modport master (
      output i_arb_read, i_arb_write, i_arb_addr, i_arb_wdata,
      output d_arb_read, d_arb_write, d_arb_addr, d_arb_wdata,
      output l2_rdata, l2_resp,
      input  i_arb_resp, d_arb_resp, arb_rdata,
      input  l2_read, l2_write, l2_addr, l2_wdata
   );
endinterface

// File: rtl/l1_arbiter.sv
// Round-robin arbiter giving the L1 I-cache or D-cache sole use of the L2 port.
// A grant is held until l2_resp; every transaction is followed by one IDLE cycle.
module l1_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 256
) (
   input  logic         clk,
   input  logic         reset,
   l1_arbiter_if.slave  bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SERVE_I = 2'd1;
   localparam logic [1:0] ST_SERVE_D = 2'd2;
   localparam logic       GRANT_I    = 1'b0;
   localparam logic       GRANT_D    = 1'b1;

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic                  last_grant_q;
   logic                  last_grant_d;
   logic                  i_req_s;
   logic                  d_req_s;
   logic                  l2_read_s;
   logic                  l2_write_s;
   logic [ADDR_WIDTH-1:0] l2_addr_s;
   logic [LINE_WIDTH-1:0] l2_wdata_s;
   logic                  i_resp_s;
   logic                  d_resp_s;

   assign i_req_s = bus.i_arb_read | bus.i_arb_write;
   assign d_req_s = bus.d_arb_read | bus.d_arb_write;

   // Next state and round-robin pointer
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_s && d_req_s) begin
               if (last_grant_q == GRANT_D) begin
                  state_d = ST_SERVE_I;
               end else begin
                  state_d = ST_SERVE_D;
               end
            end else if (i_req_s) begin
               state_d = ST_SERVE_I;
            end else if (d_req_s) begin
               state_d = ST_SERVE_D;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVE_I: begin
            if (bus.l2_resp) begin
               state_d      = ST_IDLE;
               last_grant_d = GRANT_I;
            end else if (!i_req_s) begin
               // client abandoned the transaction: release without moving the pointer
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SERVE_I;
            end
         end
         ST_SERVE_D: begin
            if (bus.l2_resp) begin
               state_d      = ST_IDLE;
               last_grant_d = GRANT_D;
            end else if (!d_req_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SERVE_D;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and grant-pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_D;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Downstream mux from the granted client's live request
   always_comb begin
      l2_read_s  = 1'b0;
      l2_write_s = 1'b0;
      l2_addr_s  = {ADDR_WIDTH{1'b0}};
      l2_wdata_s = {LINE_WIDTH{1'b0}};
      i_resp_s   = 1'b0;
      d_resp_s   = 1'b0;
      case (state_q)
         ST_SERVE_I: begin
            l2_write_s = bus.i_arb_write;
            l2_read_s  = bus.i_arb_read & ~bus.i_arb_write;
            l2_addr_s  = bus.i_arb_addr;
            l2_wdata_s = bus.i_arb_wdata;
            i_resp_s   = bus.l2_resp;
         end
         ST_SERVE_D: begin
            l2_write_s = bus.d_arb_write;
            l2_read_s  = bus.d_arb_read & ~bus.d_arb_write;
            l2_addr_s  = bus.d_arb_addr;
            l2_wdata_s = bus.d_arb_wdata;
            d_resp_s   = bus.l2_resp;
         end
         default: begin
            l2_read_s  = 1'b0;
            l2_write_s = 1'b0;
         end
      endcase
   end

   assign bus.l2_read    = l2_read_s;
   assign bus.l2_write   = l2_write_s;
   assign bus.l2_addr    = l2_addr_s;
   assign bus.l2_wdata   = l2_wdata_s;
   assign bus.i_arb_resp = i_resp_s;
   assign bus.d_arb_resp = d_resp_s;
   assign bus.arb_rdata  = bus.l2_rdata;
endmodule

// File: tb/tb_l1_arbiter.sv
// Self-checking bench for l1_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the grant owner.
module tb_l1_arbiter;
   localparam int AW = 16;
   localparam int LW = 256;
   localparam int OW = 2 + AW + LW + 2 + LW;

   typedef struct packed {
      logic          ir;
      logic          iw;
      logic [AW-1:0] ia;
      logic          dr;
      logic          dw;
      logic [AW-1:0] da;
      logic          rsp;
      logic [19:0]   ex;
   } step_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
   bit   m_last  = 1'b1; // 1 when the D-cache completed most recently

   l1_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   l1_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] e(input logic r, input logic w, input logic [AW-1:0] a,
                                     input logic ip, input logic dp);
      return {r, w, a, ip, dp};
   endfunction

   function automatic step_t row(input logic ir, input logic iw, input logic [AW-1:0] ia,
                                 input logic dr, input logic dw, input logic [AW-1:0] da,
                                 input logic rsp, input logic [19:0] ex);
      return {ir, iw, ia, dr, dw, da, rsp, ex};
   endfunction

   function automatic logic [19:0] sig();
      return {bus.l2_read, bus.l2_write, bus.l2_addr, bus.i_arb_resp, bus.d_arb_resp};
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [OW-1:0] obs_out();
      return {bus.l2_read, bus.l2_write, bus.l2_addr, bus.l2_wdata,
              bus.i_arb_resp, bus.d_arb_resp, bus.arb_rdata};
   endfunction

   // Expected outputs: whoever owns the port sees its request forwarded, write beating read.
   function automatic logic [OW-1:0] exp_out();
      logic r, w, ip, dp;
      logic [AW-1:0] a;
      logic [LW-1:0] wd;
      r = 1'b0; w = 1'b0; ip = 1'b0; dp = 1'b0; a = '0; wd = '0;
      if (m_owner == 1) begin
         w = bus.i_arb_write; r = bus.i_arb_read && !bus.i_arb_write;
         a = bus.i_arb_addr;  wd = bus.i_arb_wdata; ip = bus.l2_resp;
      end else if (m_owner == 2) begin
         w = bus.d_arb_write; r = bus.d_arb_read && !bus.d_arb_write;
         a = bus.d_arb_addr;  wd = bus.d_arb_wdata; dp = bus.l2_resp;
      end
      return {r, w, a, wd, ip, dp, bus.l2_rdata};
   endfunction

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic cyc();
      int nxt_owner;
      bit nxt_last, iq, dq, own_req;
      iq = bus.i_arb_read | bus.i_arb_write;
      dq = bus.d_arb_read | bus.d_arb_write;
      nxt_owner = m_owner;
      nxt_last  = m_last;
      if (reset) begin
         nxt_owner = 0; nxt_last = 1'b1;
      end else if (m_owner == 0) begin
         if (iq && dq)  nxt_owner = m_last ? 1 : 2;
         else if (iq)   nxt_owner = 1;
         else if (dq)   nxt_owner = 2;
      end else begin
         own_req = (m_owner == 1) ? iq : dq;
         if (bus.l2_resp) begin
            nxt_owner = 0; nxt_last = (m_owner == 2);
         end else if (!own_req) begin
            nxt_owner = 0;
         end
      end
      @(posedge clk);
      m_owner = nxt_owner;
      m_last  = nxt_last;
      @(negedge clk);
   endtask

   task automatic drive_row(input step_t s);
      bus.i_arb_read  = s.ir;
      bus.i_arb_write = s.iw;
      bus.i_arb_addr  = s.ia;
      bus.d_arb_read  = s.dr;
      bus.d_arb_write = s.dw;
      bus.d_arb_addr  = s.da;
      bus.l2_resp     = s.rsp;
   endtask

   task automatic idle_inputs();
      drive_row('0);
      bus.i_arb_wdata = '0;
      bus.d_arb_wdata = '0;
      bus.l2_rdata    = '0;
   endtask

   task automatic test_reset();
      logic [LW-1:0] rd;
      reset = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      reset = 1'b0;
      rd = rand_line();
      bus.l2_rdata = rd;
      #1;
      checks++;
      if (sig() !== 20'h0) begin
         errors++; $display("FAIL reset_strobes: got %h want %h", sig(), 20'h0);
      end
      checks++;
      if (bus.l2_wdata !== '0) begin
         errors++; $display("FAIL reset_wdata: got %h want 0", bus.l2_wdata);
      end
      checks++;
      if (bus.arb_rdata !== rd) begin
         errors++; $display("FAIL reset_rdata: got %h want %h", bus.arb_rdata, rd);
      end
      cyc();
   endtask

   task automatic test_single_read();
      step_t t[$];
      logic [LW-1:0] a5;
      a5 = {(LW / 8){8'hA5}};
      bus.l2_rdata = a5;
      t = '{row(1'b1, 1'b0, 16'h1240, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h1240, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b1, 1'b0, 16'h1240, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h1240, 1'b0, 1'b0, 16'h0000, 1'b1, e(1'b1, 1'b0, 16'h1240, 1'b1, 1'b0)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0))};
      foreach (t[k]) begin
         drive_row(t[k]);
         #1;
         checks++;
         if (sig() !== t[k].ex) begin
            errors++; $display("FAIL single_read step%0d: got %h want %h", k, sig(), t[k].ex);
         end
         if (k == 2) begin
            checks++;
            if (bus.arb_rdata !== a5) begin
               errors++; $display("FAIL single_read_rdata: got %h want %h", bus.arb_rdata, a5);
            end
         end
         cyc();
      end
   endtask

   task automatic test_simultaneous();
      step_t t[$];
      logic [LW-1:0] wd;
      reset = 1'b1;
      idle_inputs();
      cyc();
      reset = 1'b0;
      wd = rand_line();
      bus.d_arb_wdata = wd;
      t = '{row(1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 16'h2000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 16'h2000, 1'b1, e(1'b1, 1'b0, 16'h0100, 1'b1, 1'b0)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b0, e(1'b0, 1'b1, 16'h2000, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b1, e(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0))};
      foreach (t[k]) begin
         drive_row(t[k]);
         #1;
         checks++;
         if (sig() !== t[k].ex) begin
            errors++; $display("FAIL simultaneous step%0d: got %h want %h", k, sig(), t[k].ex);
         end
         if (k == 3) begin
            checks++;
            if (bus.l2_wdata !== wd) begin
               errors++; $display("FAIL simultaneous_wdata: got %h want %h", bus.l2_wdata, wd);
            end
         end
         cyc();
      end
   endtask

   task automatic test_evict_replace();
      step_t t[$];
      t = '{row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0500, 1'b0, 1'b1, 16'h3000, 1'b1, e(1'b0, 1'b1, 16'h3000, 1'b0, 1'b1)),
            row(1'b1, 1'b0, 16'h0500, 1'b1, 1'b0, 16'h4000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0500, 1'b1, 1'b0, 16'h4000, 1'b1, e(1'b1, 1'b0, 16'h0500, 1'b1, 1'b0)),
            row(1'b0, 1'b0, 16'h0500, 1'b1, 1'b0, 16'h4000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4000, 1'b1, e(1'b1, 1'b0, 16'h4000, 1'b0, 1'b1)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0))};
      foreach (t[k]) begin
         drive_row(t[k]);
         #1;
         checks++;
         if (sig() !== t[k].ex) begin
            errors++; $display("FAIL evict_replace step%0d: got %h want %h", k, sig(), t[k].ex);
         end
         cyc();
      end
   endtask

   task automatic test_long_hold();
      drive_row(row(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h6000, 1'b0, 20'h0));
      cyc();
      bus.i_arb_read = 1'b1;
      bus.i_arb_addr = 16'h7000;
      for (int n = 0; n < 20; n++) begin
         #1;
         checks++;
         if (sig() !== e(1'b1, 1'b0, 16'h6000, 1'b0, 1'b0)) begin
            errors++; $display("FAIL long_hold cyc%0d: got %h want %h", n, sig(), e(1'b1, 1'b0, 16'h6000, 1'b0, 1'b0));
         end
         cyc();
      end
      bus.l2_resp = 1'b1;
      cyc();
      bus.l2_resp = 1'b0;
      bus.d_arb_read = 1'b0;
      cyc();
      #1;
      checks++;
      if (sig() !== e(1'b1, 1'b0, 16'h7000, 1'b0, 1'b0)) begin
         errors++; $display("FAIL long_hold_then_i: got %h want %h", sig(), e(1'b1, 1'b0, 16'h7000, 1'b0, 1'b0));
      end
      bus.l2_resp = 1'b1;
      cyc();
      idle_inputs();
      cyc();
   endtask

   task automatic test_reset_mid();
      drive_row(row(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 20'h0));
      cyc();
      #1;
      checks++;
      if (sig() !== e(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0)) begin
         errors++; $display("FAIL reset_mid_grant: got %h want %h", sig(), e(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0));
      end
      reset = 1'b1;
      bus.l2_resp = 1'b1;
      cyc();
      reset = 1'b0;
      drive_row(row(1'b1, 1'b0, 16'h9000, 1'b1, 1'b0, 16'h8000, 1'b0, 20'h0));
      #1;
      checks++;
      if (sig() !== 20'h0) begin
         errors++; $display("FAIL reset_mid_idle: got %h want %h", sig(), 20'h0);
      end
      cyc();
      #1;
      checks++;
      if (sig() !== e(1'b1, 1'b0, 16'h9000, 1'b0, 1'b0)) begin
         errors++; $display("FAIL reset_mid_rr: got %h want %h", sig(), e(1'b1, 1'b0, 16'h9000, 1'b0, 1'b0));
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_drop();
      step_t t[$];
      reset = 1'b1;
      idle_inputs();
      cyc();
      reset = 1'b0;
      t = '{row(1'b1, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0B00, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0B00, 1'b0, e(1'b1, 1'b0, 16'h0A00, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0B00, 1'b0, e(1'b0, 1'b0, 16'h0A00, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0B00, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0B00, 1'b1, e(1'b1, 1'b0, 16'h0B00, 1'b0, 1'b1)),
            row(1'b1, 1'b0, 16'h0C00, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0C00, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b1, 1'b0, 16'h0C00, 1'b0, 1'b0)),
            row(1'b0, 1'b0, 16'h0C00, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0C00, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0D00, 1'b1, 1'b0, 16'h0E00, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)),
            row(1'b1, 1'b0, 16'h0D00, 1'b1, 1'b0, 16'h0E00, 1'b1, e(1'b1, 1'b0, 16'h0D00, 1'b1, 1'b0)),
            row(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, e(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0))};
      foreach (t[k]) begin
         drive_row(t[k]);
         #1;
         checks++;
         if (sig() !== t[k].ex) begin
            errors++; $display("FAIL drop step%0d: got %h want %h", k, sig(), t[k].ex);
         end
         cyc();
      end
   endtask

   task automatic test_random();
      logic [OW-1:0] exp_v;
      for (int n = 0; n < 600; n++) begin
         reset           = ($urandom_range(0, 49) == 0);
         bus.i_arb_read  = 1'($urandom_range(0, 1));
         bus.i_arb_write = ($urandom_range(0, 7) == 0);
         bus.i_arb_addr  = 16'($urandom);
         bus.i_arb_wdata = rand_line();
         bus.d_arb_read  = 1'($urandom_range(0, 1));
         bus.d_arb_write = ($urandom_range(0, 2) == 0);
         bus.d_arb_addr  = 16'($urandom);
         bus.d_arb_wdata = rand_line();
         bus.l2_rdata    = rand_line();
         bus.l2_resp     = ($urandom_range(0, 3) == 0);
         #1;
         exp_v = exp_out();
         checks++;
         if (obs_out() !== exp_v) begin
            errors++; $display("FAIL random cyc%0d: got %h want %h", n, obs_out(), exp_v);
         end
         cyc();
      end
      reset = 1'b0;
      idle_inputs();
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single_read();
      test_simultaneous();
      test_evict_replace();
      test_long_hold();
      test_reset_mid();
      test_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
